// File: rtl/bit_serial_alu_ctrl_if.sv
// Request/response bundle between the issuing stage and the bit-serial ALU sequencer.
interface bit_serial_alu_ctrl_if #(
  parameter int unsigned WIDTH = 64
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] result;
  logic             flag_n;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;

  modport master (
    output start, op, a, b,
    input  busy, done, err, result, flag_n, flag_z, flag_c, flag_v
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, err, result, flag_n, flag_z, flag_c, flag_v
  );
endinterface

// File: rtl/bit_serial_alu_ctrl.sv
// Sequencer for a 1-bit adder/logic slice: streams operand bits LSB first through the
// slice, keeps the ripple carry locally and assembles the result plus NZCV flags.
module bit_serial_alu_ctrl #(
  parameter int unsigned WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  bit_serial_alu_ctrl_if.slave bus,
  output logic                 slice_A,
  output logic                 slice_B,
  output logic                 slice_Cin,
  output logic                 slice_Cout_sel,
  output logic [1:0]           slice_sum_sel,
  input  logic                 slice_sum,
  input  logic                 slice_Cout
);

  localparam int unsigned CntW = $clog2(WIDTH);

  localparam logic [2:0] OpAnd   = 3'b000;
  localparam logic [2:0] OpOr    = 3'b001;
  localparam logic [2:0] OpPassB = 3'b010;
  localparam logic [2:0] OpAdd   = 3'b011;
  localparam logic [2:0] OpSub   = 3'b100;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic [WIDTH-1:0]  res_sh_q, res_sh_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [2:0]        op_q, op_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic              flag_n_q, flag_n_d;
  logic              flag_z_q, flag_z_d;
  logic              flag_c_q, flag_c_d;
  logic              flag_v_q, flag_v_d;

  logic              is_arith, is_sub, is_illegal, last_bit;
  logic [WIDTH-1:0]  res_next;

  assign is_sub     = (op_q == OpSub);
  assign is_arith   = (op_q == OpAdd) || is_sub;
  assign is_illegal = (op_q > OpSub);
  assign last_bit   = (cnt_q == CntW'(WIDTH - 1));
  assign res_next   = {slice_sum, res_sh_q[WIDTH-1:1]};

  // State and datapath registers; reset returns everything to idle with cleared outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      result_q <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      flag_n_q <= 1'b0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
      flag_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      result_q <= result_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      flag_n_q <= flag_n_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
      flag_v_q <= flag_v_d;
    end
  end

  // Next-state: accept in idle, shift one bit per run cycle, commit result on the last bit.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    result_d = result_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    flag_n_d = flag_n_q;
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
    flag_v_d = flag_v_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StRun;
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          op_d    = bus.op;
          cnt_d   = '0;
          // Subtraction is a + ~b + 1; the +1 enters as the initial carry.
          carry_d = (bus.op == OpSub);
        end
      end
      StRun: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = res_next;
        carry_d  = is_arith & slice_Cout;
        if (last_bit) begin
          state_d = StDone;
          if (is_illegal) begin
            result_d = '0;
            flag_n_d = 1'b0;
            flag_z_d = 1'b0;
            flag_c_d = 1'b0;
            flag_v_d = 1'b0;
          end else begin
            result_d = res_next;
            flag_n_d = res_next[WIDTH-1];
            flag_z_d = (res_next == '0);
            flag_c_d = is_arith & slice_Cout;
            // Overflow: carry into the MSB differs from carry out of it.
            flag_v_d = is_arith & (carry_q ^ slice_Cout);
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Slice drive: only meaningful while running, held at zero otherwise.
  always_comb begin
    slice_A        = 1'b0;
    slice_B        = 1'b0;
    slice_Cin      = 1'b0;
    slice_Cout_sel = 1'b0;
    slice_sum_sel  = 2'b00;
    if (state_q == StRun) begin
      slice_A        = a_sh_q[0];
      slice_B        = b_sh_q[0] ^ is_sub;
      slice_Cin      = carry_q;
      slice_Cout_sel = is_arith;
      case (op_q)
        OpAdd, OpSub: slice_sum_sel = 2'b11;
        OpPassB:      slice_sum_sel = 2'b10;
        OpOr:         slice_sum_sel = 2'b01;
        default:      slice_sum_sel = 2'b00;
      endcase
    end
  end

  // Status and held result/flags to the bus.
  always_comb begin
    bus.busy   = (state_q == StRun);
    bus.done   = (state_q == StDone);
    bus.err    = (state_q == StDone) && is_illegal;
    bus.result = result_q;
    bus.flag_n = flag_n_q;
    bus.flag_z = flag_z_q;
    bus.flag_c = flag_c_q;
    bus.flag_v = flag_v_q;
  end

endmodule
